mem_write_checker: RTL
======================

MEM_WRITE_CHECKER -- requirements
Module: mem_write_checker

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 Parameters SHALL be as follows (name, default, meaning):
- DATA_W, 32, writedata width.
- ADDR_W, 32, dataadr width.
- N_EXP, 4, expected-write table depth (legal range 1..16).
- IGNORE_ADDR, 80, address whose writes are never checked.
- TIMEOUT_CYC, 1000, RUN-cycle budget.
REQ-003 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1, clock (rising edge).
- reset, in, 1, synchronous active-high reset.
- memwrite, in, 1, DUT store strobe.
- dataadr, in, ADDR_W, DUT store address.
- writedata, in, DATA_W, DUT store data.
- exp_we, in, 1, append an expected entry.
- exp_addr, in, ADDR_W, expected address.
- exp_data, in, DATA_W, expected data.
- start, in, 1, begin checking.
- busy, out, 1, checker in RUN.
- pass, out, 1, all expected writes matched.
- fail, out, 1, check failed.
- fail_code, out, 2, failure cause.
- fail_addr, out, ADDR_W, offending address.
- fail_data, out, DATA_W, offending data.
- match_cnt, out, clog2(N_EXP+1), number of writes matched so far.

Function
REQ-004 The FSM SHALL have four states: IDLE, RUN, PASS and FAIL; PASS and FAIL SHALL be terminal until reset.
REQ-005 In IDLE, exp_we SHALL store {exp_addr, exp_data} at the load pointer and increment the load count; exp_we SHALL be ignored when the count equals N_EXP, and in any state other than IDLE.
REQ-006 start in IDLE with load count of 1 or more SHALL move the FSM to RUN on the next edge; start with count 0, or start in any other state, SHALL be ignored.
REQ-007 exp_we and start asserted in the same IDLE cycle SHALL store the entry first; the stored entry SHALL count towards the start condition.
REQ-008 In RUN, on each rising edge with memwrite=1 and dataadr!=IGNORE_ADDR, the store SHALL be compared against entry[match_cnt]; writes to IGNORE_ADDR SHALL have no effect.
REQ-009 When both address and data match, match_cnt SHALL increment; if the new value equals the load count, the FSM SHALL enter PASS on the same edge.
REQ-010 When either field mismatches, the FSM SHALL enter FAIL with fail_code=01 (MISMATCH), and fail_addr/fail_data SHALL capture dataadr/writedata.
REQ-011 Writes in IDLE, PASS or FAIL SHALL be ignored, and the failure capture registers SHALL remain frozen.
REQ-012 All outputs SHALL be registered: busy=(state==RUN), pass=(state==PASS), fail=(state==FAIL); a verdict SHALL be visible one cycle after the deciding edge.
REQ-013 fail_code SHALL encode 00 NONE, 01 MISMATCH, 10 TIMEOUT; 11 is reserved and SHALL never be produced.
REQ-014 The timeout counter SHALL clear on entry to RUN and increment once per RUN cycle; when it reaches TIMEOUT_CYC with no verdict, the FSM SHALL enter FAIL with fail_code=10, fail_addr=0 and fail_data=0.
REQ-015 When a final match and the timeout coincide, PASS SHALL win; when a mismatch and the timeout coincide, MISMATCH SHALL win.

Reset
REQ-016 reset SHALL force IDLE, clear every output, match_cnt, the load count and the timeout counter to 0, and SHALL dominate start and exp_we.
REQ-017 reset asserted mid-RUN SHALL abort the check; the table SHALL be treated as empty and reloaded before the next start.

Configuration
REQ-018 With MWC_TIMEOUT_EN defined, the timeout counter and fail_code 10 SHALL be implemented.
REQ-019 With MWC_TIMEOUT_EN undefined, no timeout counter SHALL be synthesised, RUN SHALL wait indefinitely, and fail_code 10 SHALL never occur.

Structure
REQ-020 Package mwc_pkg SHALL hold the state enum and the FAIL_NONE, FAIL_MISMATCH and FAIL_TIMEOUT constants.
REQ-021 Sub-module mwc_exp_table SHALL implement the N_EXP-deep register array, write pointer, count and indexed read port.

Verification
REQ-022 The bench SHALL cover the following scenarios:
- Load (50,0); start; DUT stores 550-550 to 50 -> pass=1 the cycle after the store, match_cnt=1, fail=0.
- Load (50,0); store (80,7) then (50,0) -> the write to 80 is ignored; pass=1.
- Load (50,0); store (50,5) -> fail=1, fail_code=01, fail_addr=50, fail_data=5.
- With MWC_TIMEOUT_EN and TIMEOUT_CYC=100: load (50,0), start, no stores -> fail=1, fail_code=10, 101 cycles after start.
- N_EXP=2: load 3 entries -> third ignored; stores (10,1),(20,2) -> pass, match_cnt=2.
- reset mid-RUN after one match -> all outputs 0, IDLE; start without reload is ignored.

Source files
------------

// File: rtl/mwc_pkg.sv
// Shared types and failure codes for the memory-write checker.
package mwc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PASS,
    ST_FAIL
  } state_t;

  localparam logic [1:0] FAIL_NONE     = 2'b00;
  localparam logic [1:0] FAIL_MISMATCH = 2'b01;
  localparam logic [1:0] FAIL_TIMEOUT  = 2'b10;

endpackage

// File: rtl/mwc_exp_table.sv
// Expected-write table: N_EXP-deep {addr,data} store with append-only write
// pointer (the fill count) and a combinational indexed read port.
module mwc_exp_table #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned N_EXP  = 4,
  parameter int unsigned CNT_W  = $clog2(N_EXP + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CNT_W-1:0]  i_rd_idx,
  output logic [CNT_W-1:0]  o_count,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [ADDR_W-1:0] r_addr [N_EXP];
  logic [DATA_W-1:0] r_data [N_EXP];
  logic [CNT_W-1:0]  r_count;
  logic              w_wr;

  assign w_wr    = i_we && (r_count != CNT_W'(N_EXP));
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (reset) r_count <= '0;
    else if (w_wr) r_count <= r_count + CNT_W'(1);
  end

  // The count doubles as the write pointer; entries are not cleared on reset
  // because a zero count already marks them invalid.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_EXP; i++) begin
      if (w_wr && (r_count == CNT_W'(i))) begin
        r_addr[i] <= i_addr;
        r_data[i] <= i_data;
      end
    end
  end

  always_comb begin
    o_rd_addr = '0;
    o_rd_data = '0;
    for (int unsigned i = 0; i < N_EXP; i++) begin
      if (i_rd_idx == CNT_W'(i)) begin
        o_rd_addr = r_addr[i];
        o_rd_data = r_data[i];
      end
    end
  end

endmodule

// File: rtl/mem_write_checker.sv
// Checks a DUT's store stream against a preloaded list of expected writes.
// Optional RUN timeout enabled by defining MWC_TIMEOUT_EN.
module mem_write_checker
  import mwc_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned N_EXP       = 4,
  parameter int unsigned IGNORE_ADDR = 80,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        memwrite,
  input  logic [ADDR_W-1:0]           dataadr,
  input  logic [DATA_W-1:0]           writedata,
  input  logic                        exp_we,
  input  logic [ADDR_W-1:0]           exp_addr,
  input  logic [DATA_W-1:0]           exp_data,
  input  logic                        start,
  output logic                        busy,
  output logic                        pass,
  output logic                        fail,
  output logic [1:0]                  fail_code,
  output logic [ADDR_W-1:0]           fail_addr,
  output logic [DATA_W-1:0]           fail_data,
  output logic [$clog2(N_EXP+1)-1:0]  match_cnt
);

  localparam int unsigned CNT_W = $clog2(N_EXP + 1);

  state_t            r_state;
  logic              w_tab_we;
  logic [CNT_W-1:0]  w_count;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [DATA_W-1:0] w_rd_data;
  logic [CNT_W-1:0]  w_next_cnt;
  logic              w_store;
  logic              w_hit;
  logic              w_final;
  logic              w_mis;
  logic              w_start_ok;
  logic              w_tmo;

  assign w_tab_we = exp_we && (r_state == ST_IDLE);

  mwc_exp_table #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .N_EXP  (N_EXP),
    .CNT_W  (CNT_W)
  ) u_table (
    .clk       (clk),
    .reset     (reset),
    .i_we      (w_tab_we),
    .i_addr    (exp_addr),
    .i_data    (exp_data),
    .i_rd_idx  (match_cnt),
    .o_count   (w_count),
    .o_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  // An entry written in the same cycle as start counts towards the start condition.
  assign w_start_ok = start && ((w_count != '0) || w_tab_we);
  assign w_store    = memwrite && (dataadr != ADDR_W'(IGNORE_ADDR));
  assign w_hit      = w_store && (dataadr == w_rd_addr) && (writedata == w_rd_data);
  assign w_mis      = w_store && !w_hit;
  assign w_next_cnt = match_cnt + CNT_W'(1);
  assign w_final    = w_hit && (w_next_cnt == w_count);

`ifdef MWC_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] r_tmo;

  always_ff @(posedge clk) begin
    if (reset || (r_state != ST_RUN)) r_tmo <= '0;
    else if (!w_tmo) r_tmo <= r_tmo + TMO_W'(1);
  end

  assign w_tmo = (r_tmo == TMO_W'(TIMEOUT_CYC));
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      busy      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      fail_code <= FAIL_NONE;
      fail_addr <= '0;
      fail_data <= '0;
      match_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_state   <= ST_RUN;
            busy      <= 1'b1;
            match_cnt <= '0;
          end
        end
        ST_RUN: begin
          if (w_hit) match_cnt <= w_next_cnt;
          // Priority: final match, then mismatch, then timeout.
          if (w_final) begin
            r_state <= ST_PASS;
            busy    <= 1'b0;
            pass    <= 1'b1;
          end else if (w_mis) begin
            r_state   <= ST_FAIL;
            busy      <= 1'b0;
            fail      <= 1'b1;
            fail_code <= FAIL_MISMATCH;
            fail_addr <= dataadr;
            fail_data <= writedata;
          end else if (w_tmo) begin
            r_state   <= ST_FAIL;
            busy      <= 1'b0;
            fail      <= 1'b1;
            fail_code <= FAIL_TIMEOUT;
            fail_addr <= '0;
            fail_data <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
